conv2d_stream_engine: RTL and testbench

Streaming 2-D convolution engine, the parametrised successor to the fixed single-column sliding-window MAC. It accepts one signed pixel per cycle in raster order over a valid/ready handshake and builds the KxK window internally with line buffers. It applies a runtime-loadable signed kernel through a pipelined multiplier/adder tree, then rounds, shifts and saturates. Sits between the pixel source (DMA/previous layer) and the activation/pooling stage of the CNN datapath.

---
 rtl/conv2d_pkg.sv | 67 ++++++
 rtl/conv2d_line_buffer.sv | 48 ++++
 rtl/conv2d_stream_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_pkg
// Description : Shared helpers for the streaming 2-D convolution engine:
//               clog2, coefficient index width, saturation bounds and the
//               round-half-up / arithmetic-shift / saturate output function.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package conv2d_pkg;

    // Width used for all intermediate rounding arithmetic; accumulators up to
    // this width are handled without loss.
    localparam int c_MAX_ACC_WIDTH = 64;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a coefficient index for a KxK kernel (never narrower than 1).
    function automatic int coef_idx_width(input int k);
        return (clog2(k * k) < 1) ? 1 : clog2(k * k);
    endfunction

    // Largest positive value of a signed dw-bit number.
    function automatic logic signed [c_MAX_ACC_WIDTH-1:0] sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    // Most negative value of a signed dw-bit number.
    function automatic logic signed [c_MAX_ACC_WIDTH-1:0] sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    // Saturation bounds for the default 16-bit pixel width.
    localparam logic signed [c_MAX_ACC_WIDTH-1:0] c_SAT_MAX_16 = 64'sd32767;
    localparam logic signed [c_MAX_ACC_WIDTH-1:0] c_SAT_MIN_16 = -64'sd32768;

    // Round half up, arithmetic shift right, then clamp to a signed dw-bit range.
    // Done at full 64-bit width so the rounding constant can never overflow
    // the accumulator.
    function automatic logic signed [c_MAX_ACC_WIDTH-1:0] round_shift_sat(
        input logic signed [c_MAX_ACC_WIDTH-1:0] acc,
        input int                                shift,
        input int                                dw
    );
        logic signed [c_MAX_ACC_WIDTH-1:0] v;
        v = acc;
        if (shift > 0) begin
            v = v + (64'sd1 <<< (shift - 1));
        end
        v = v >>> shift;
        if (v > sat_max(dw)) begin
            v = sat_max(dw);
        end else if (v < sat_min(dw)) begin
            v = sat_min(dw);
        end
        return v;
    endfunction

endpackage : conv2d_pkg
`default_nettype wire

// File: rtl/conv2d_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_line_buffer
// Description : Circular line delay of DEPTH accepted pixels. The output is
//               the pixel written DEPTH enables ago, i.e. the pixel directly
//               above the current one when DEPTH equals the line width.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module conv2d_line_buffer
    import conv2d_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int                 c_PTR_W    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_ptr;

    // Read-before-write at the same slot: the old entry is the line-above pixel.
    assign o_data = r_mem[r_ptr];

    // Storage is never reset; stale contents only feed windows flagged invalid.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_data;
        end
    end

    // Circular pointer advancing once per accepted pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + c_PTR_W'(1);
        end
    end

endmodule : conv2d_line_buffer
`default_nettype wire

// File: rtl/conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_stream_engine
// Description : Streaming KxK signed convolution. Raster pixels in over
//               valid/ready, window built from K-1 cascaded line buffers,
//               four-stage pipeline (window, products, sum, round/saturate)
//               that moves only when the output register can take data.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module conv2d_stream_engine
    import conv2d_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int K          = 3,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_SHIFT  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_WIDTH-1:0]      in_data,
    input  logic                              in_sof,
    input  logic                              coef_we,
    input  logic [coef_idx_width(K)-1:0]      coef_addr,
    input  logic signed [COEF_WIDTH-1:0]      coef_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_WIDTH-1:0]      out_data,
    output logic                              out_last
);

    localparam int c_TAPS   = K * K;
    localparam int c_PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int c_COL_W  = (clog2(IMG_WIDTH) < 1) ? 1 : clog2(IMG_WIDTH);
    localparam int c_ROW_W  = (clog2(IMG_HEIGHT) < 1) ? 1 : clog2(IMG_HEIGHT);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_out_valid;
    logic w_advance;
    logic w_accept;

    assign w_advance = ~r_out_valid | out_ready;
    // Held low while reset is asserted so nothing is accepted into a clearing pipe.
    assign in_ready  = w_advance & ~reset;
    assign w_accept  = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Position of the pixel being accepted
    // ------------------------------------------------------------------
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] w_pix_col;
    logic [c_ROW_W-1:0] w_pix_row;
    logic               w_col_wrap;
    logic               w_row_wrap;
    logic               w_win_ok;
    logic               w_last_pos;

    // Start-of-frame overrides the running counters for this pixel.
    assign w_pix_col  = in_sof ? '0 : r_col;
    assign w_pix_row  = in_sof ? '0 : r_row;
    assign w_col_wrap = (int'(w_pix_col) == IMG_WIDTH - 1);
    assign w_row_wrap = (int'(w_pix_row) == IMG_HEIGHT - 1);
    assign w_win_ok   = (int'(w_pix_col) >= K - 1) && (int'(w_pix_row) >= K - 1);
    assign w_last_pos = w_col_wrap & w_row_wrap;

    // Raster counters hold the position the next accepted pixel will take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : w_pix_row + c_ROW_W'(1);
            end else begin
                r_col <= w_pix_col + c_COL_W'(1);
                r_row <= w_pix_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer cascade: column[K-1] is the new pixel, column[0] the
    // pixel K-1 lines above it.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]        w_lb_out [K-1];
    logic signed [DATA_WIDTH-1:0] w_column [K];

    assign w_column[K-1] = in_data;

    for (genvar gi = 0; gi < K - 1; gi++) begin : g_line_buf
        logic [DATA_WIDTH-1:0] w_lb_in;

        if (gi == 0) begin : g_first
            assign w_lb_in = in_data;
        end else begin : g_chain
            assign w_lb_in = w_lb_out[gi-1];
        end

        conv2d_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH)
        ) u_line_buffer (
            .clk    (clk),
            .reset  (reset),
            .i_en   (w_accept),
            .i_data (w_lb_in),
            .o_data (w_lb_out[gi])
        );

        assign w_column[K-2-gi] = w_lb_out[gi];
    end

    // ------------------------------------------------------------------
    // Coefficient bank, index row*K+col, written independently of advance
    // ------------------------------------------------------------------
    logic signed [COEF_WIDTH-1:0] r_coef [c_TAPS];

    // Out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (coef_we && (int'(coef_addr) < c_TAPS)) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    // ------------------------------------------------------------------
    // S1: window register, index row*K+col, row 0 = oldest line
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] r_win [c_TAPS];
    logic                         r_v1;
    logic                         r_l1;

    // Shift window left on each accepted pixel and tag whether it is complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_TAPS; i++) begin
                r_win[i] <= '0;
            end
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
        end else if (w_advance) begin
            r_v1 <= w_accept & w_win_ok;
            r_l1 <= w_accept & w_win_ok & w_last_pos;
            if (w_accept) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        r_win[r*K+c] <= r_win[r*K+c+1];
                    end
                    r_win[r*K+K-1] <= w_column[r];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: per-tap signed products
    // ------------------------------------------------------------------
    logic signed [c_PROD_W-1:0] r_prod [c_TAPS];
    logic                       r_v2;
    logic                       r_l2;

    // Register every window*coefficient product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_TAPS; i++) begin
                r_prod[i] <= '0;
            end
            r_v2 <= 1'b0;
            r_l2 <= 1'b0;
        end else if (w_advance) begin
            for (int i = 0; i < c_TAPS; i++) begin
                r_prod[i] <= c_PROD_W'(r_win[i]) * c_PROD_W'(r_coef[i]);
            end
            r_v2 <= r_v1;
            r_l2 <= r_l1;
        end
    end

    // ------------------------------------------------------------------
    // S3: adder tree into the accumulator width
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] r_sum;
    logic                        r_v3;
    logic                        r_l3;

    // Sign-extend every product and sum them.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_TAPS; i++) begin
            w_sum = w_sum + ACC_WIDTH'(r_prod[i]);
        end
    end

    // Register the full sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
            r_v3  <= 1'b0;
            r_l3  <= 1'b0;
        end else if (w_advance) begin
            r_sum <= w_sum;
            r_v3  <= r_v2;
            r_l3  <= r_l2;
        end
    end

    // ------------------------------------------------------------------
    // S4: round, shift, saturate into the output register
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic                         r_out_last;

    // Output register holds steady whenever the downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_advance) begin
            r_out_data  <= DATA_WIDTH'(round_shift_sat(64'(r_sum), OUT_SHIFT, DATA_WIDTH));
            r_out_valid <= r_v3;
            r_out_last  <= r_l3;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule : conv2d_stream_engine
`default_nettype wire

// File: tb/tb_conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_stream_engine
// Description : Directed bench for conv2d_stream_engine on a 5x4 image with a
//               3x3 kernel. A frame-array model computes every expected window
//               result; one compare process checks each output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_stream_engine;

    localparam int DATA_WIDTH = 16;
    localparam int COEF_WIDTH = 16;
    localparam int K          = 3;
    localparam int IMG_WIDTH  = 5;
    localparam int IMG_HEIGHT = 4;
    localparam int ACC_WIDTH  = 40;
    localparam int OUT_SHIFT  = 8;
    localparam int IDX_W      = 4;
    localparam int NPIX       = IMG_WIDTH * IMG_HEIGHT;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_sof;
    logic                         coef_we;
    logic [IDX_W-1:0]             coef_addr;
    logic signed [COEF_WIDTH-1:0] coef_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_last;

    conv2d_stream_engine #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .K          (K),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_SHIFT  (OUT_SHIFT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_coef [K*K];
    longint m_frame [IMG_HEIGHT][IMG_WIDTH];
    int     m_col = 0;
    int     m_row = 0;
    longint exp_data_q [$];
    bit     exp_last_q [$];

    // Spec arithmetic: floor((sum + half) / 2^shift), clamped to 16 bits.
    function automatic longint model_result(input longint s);
        longint d, n, q;
        d = longint'(1) << OUT_SHIFT;
        n = s + ((OUT_SHIFT > 0) ? (d / 2) : 0);
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    bit     arm_latency = 0;
    bit     lat_pending = 0;
    int     lat_ref_cyc = 0;

    task automatic model_accept(input longint d, input bit sof);
        longint s;
        if (sof) begin
            m_col = 0;
            m_row = 0;
        end
        m_frame[m_row][m_col] = d;
        if (m_col >= K - 1 && m_row >= K - 1) begin
            s = 0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    s = s + m_frame[m_row-K+1+r][m_col-K+1+c] * m_coef[r*K+c];
            exp_data_q.push_back(model_result(s));
            exp_last_q.push_back(m_col == IMG_WIDTH - 1 && m_row == IMG_HEIGHT - 1);
            if (arm_latency) begin
                arm_latency = 0;
                lat_pending = 1;
                lat_ref_cyc = cyc;
            end
        end
        m_col = m_col + 1;
        if (m_col == IMG_WIDTH) begin
            m_col = 0;
            m_row = (m_row == IMG_HEIGHT - 1) ? 0 : m_row + 1;
        end
    endtask

    // ---------------- output-side backpressure ----------------
    int stall_from = 1000000;
    always @(negedge clk) out_ready = !(cyc >= stall_from && cyc < stall_from + 5);

    // ---------------- compare process ----------------
    longint got_q [$];
    bit     got_last_q [$];
    bit     hold_v = 0;
    longint hold_d = 0;
    bit     hold_l = 0;
    int     stall_cnt = 0;

    always @(negedge clk) begin
        #2;
        if (reset) begin
            hold_v = 0;
        end else begin
            check("in_ready_rule", in_ready, (!out_valid || out_ready));
            if (hold_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
                check("hold_last", out_last, hold_l);
            end
            if (out_valid && lat_pending) begin
                check("first_latency", cyc - lat_ref_cyc, 4);
                lat_pending = 0;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(longint'(out_data));
                got_last_q.push_back(out_last);
                if (exp_data_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("out_data", out_data, exp_data_q.pop_front());
                    check("out_last", out_last, exp_last_q.pop_front());
                end
            end
            if (out_valid && !out_ready) stall_cnt = stall_cnt + 1;
            hold_v = out_valid && !out_ready;
            hold_d = longint'(out_data);
            hold_l = out_last;
        end
    end

    function automatic longint got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : -99999;
    endfunction

    function automatic int last_count();
        int n = 0;
        foreach (got_last_q[i]) n = n + got_last_q[i];
        return n;
    endfunction

    // ---------------- stimulus tasks (entered at a falling edge) ----------------
    task automatic write_coef(input int addr, input longint val);
        coef_we   = 1'b1;
        coef_addr = IDX_W'(addr);
        coef_data = COEF_WIDTH'(val);
        @(negedge clk);
        coef_we   = 1'b0;
        if (addr < K * K) m_coef[addr] = val;
    endtask

    // Fill every tap with 'fill' except tap 'idx' (if >= 0); then poke every
    // out-of-range address with junk that must be ignored.
    task automatic load_kernel(input longint fill, input int idx, input longint at_idx);
        for (int a = 0; a < K * K; a++) write_coef(a, (a == idx) ? at_idx : fill);
        for (int a = K * K; a < 16; a++) write_coef(a, 16'sh1234);
    endtask

    task automatic send_pixel(input longint d, input bit sof);
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = DATA_WIDTH'(d);
        in_sof   = sof;
        for (int t = 0; t < 100 && !acc; t++) begin
            #1;
            if (in_ready) begin
                acc = 1;
                model_accept(d, sof);
            end
            @(negedge clk);
        end
        if (!acc) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // mode 0: constant 'base'; mode 1: ramp base+index.
    task automatic send_frame(input int mode, input longint base, input bit sof);
        for (int i = 0; i < NPIX; i++)
            send_pixel((mode == 0) ? base : base + i, sof && (i == 0));
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_data_q.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t = t + 1;
        end
        if (t >= 200) check("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic new_capture();
        got_q.delete();
        got_last_q.delete();
    endtask

    longint ref_q [$];

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sof    = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        foreach (m_coef[i]) m_coef[i] = 0;
        foreach (m_frame[r, c]) m_frame[r][c] = 0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: all-ones window, coef 256 with shift 8 behaves as unit weights -> 9
        load_kernel(256, -1, 0);
        new_capture();
        arm_latency = 1;
        send_frame(0, 1, 1);
        wait_drain();
        check("c1_count", got_q.size(), 6);
        check("c1_first", got_at(0), 9);
        check("c1_sixth", got_at(5), 9);
        check("c1_last_on_6th", (got_last_q.size() == 6) ? got_last_q[5] : 0, 1);
        check("c1_last_count", last_count(), 1);
        check("c1_latency_seen", lat_pending, 0);

        // 2: centre tap picks the window centre of a ramp
        load_kernel(0, 4, 256);
        new_capture();
        send_frame(1, 0, 1);
        wait_drain();
        check("c2_count", got_q.size(), 6);
        check("c2_first", got_at(0), 6);
        check("c2_fourth", got_at(3), 11);
        check("c2_sixth", got_at(5), 13);
        ref_q = got_q;

        // 3: saturation both ways, then rounding of +/-384
        load_kernel(256, -1, 0);
        new_capture();
        send_frame(0, 32767, 1);
        wait_drain();
        check("c3_sat_pos", got_at(0), 32767);
        new_capture();
        send_frame(0, -32768, 1);
        wait_drain();
        check("c3_sat_neg", got_at(0), -32768);
        load_kernel(0, 0, 384);
        new_capture();
        send_frame(0, 1, 1);
        wait_drain();
        check("c3_round_pos", got_at(0), 2);
        new_capture();
        send_frame(0, -1, 1);
        wait_drain();
        check("c3_round_neg", got_at(0), -1);

        // 4: five-cycle output stall mid-stream must not lose or repeat data
        load_kernel(0, 4, 256);
        new_capture();
        stall_cnt  = 0;
        stall_from = cyc + 15;
        send_frame(1, 0, 1);
        wait_drain();
        stall_from = 1000000;
        check("c4_stall_seen", (stall_cnt >= 3) ? 1 : 0, 1);
        check("c4_count", got_q.size(), ref_q.size());
        for (int i = 0; i < 6; i++) check("c4_same_as_unstalled", got_at(i), ref_q[i]);

        // 5: in_sof at pixel 7 restarts the frame
        new_capture();
        for (int i = 0; i < 7; i++) send_pixel(i, i == 0);
        send_frame(1, 100, 1);
        wait_drain();
        check("c5_count", got_q.size(), 6);
        check("c5_first", got_at(0), 106);
        check("c5_sixth", got_at(5), 113);
        check("c5_last_count", last_count(), 1);

        // 6: reset while results are flowing
        load_kernel(256, -1, 0);
        for (int i = 0; i < 19; i++) send_pixel(1, i == 0);
        for (int t = 0; t < 10 && !out_valid; t++) @(negedge clk);
        check("c6_valid_before_reset", out_valid, 1);
        #3;
        reset = 1'b1;
        #1;
        check("c6_rst_out_valid", out_valid, 0);
        check("c6_rst_out_data", out_data, 0);
        check("c6_rst_out_last", out_last, 0);
        exp_data_q.delete();
        exp_last_q.delete();
        m_col = 0;
        m_row = 0;
        foreach (m_coef[i]) m_coef[i] = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // cleared coefficients, no in_sof: counters must already be at origin
        new_capture();
        send_frame(0, 1, 0);
        wait_drain();
        check("c6_zero_coef_count", got_q.size(), 6);
        check("c6_zero_coef_first", got_at(0), 0);
        load_kernel(256, -1, 0);
        new_capture();
        send_frame(0, 1, 1);
        wait_drain();
        check("c6_count", got_q.size(), 6);
        check("c6_first", got_at(0), 9);
        check("c6_last_count", last_count(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_conv2d_stream_engine
`default_nettype wire
